target_reset_action_ctrl: RTL

Parametrised I3C target-reset engine for the target-side controller.
- Detects the Target Reset Pattern: N SDA transitions while SCL is low, then Sr, then P.
- Applies the RSTACT-configured action, or the default escalation policy (first pattern resets the peripheral, the next consecutive one resets the whole target).
- Sits beside the bus monitor, consuming its SCL/SDA edge and start/stop strobes; drives reset requests to the top level.

---
 rtl/target_reset_action_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/target_reset_action_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : target_reset_action_ctrl
// Brief   : I3C Target Reset Pattern detector and RSTACT/escalation action engine.
//           Optional escalation window timer: TARGET_RESET_ESCALATION_TIMEOUT_EN
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module target_reset_action_ctrl #(
    parameter int PATTERN_TRANSITIONS = 14,
    parameter int CNT_W               = $clog2(PATTERN_TRANSITIONS + 1),
    parameter int TIMEOUT_W           = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 scl_low_i,
    input  logic                 scl_high_i,
    input  logic                 sda_posedge_i,
    input  logic                 sda_negedge_i,
    input  logic                 start_detected_i,
    input  logic                 stop_detected_i,
    input  logic                 rstact_valid_i,
    input  logic [7:0]           rstact_i,
    input  logic                 escalation_clear_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    output logic                 pattern_detect_o,
    output logic                 periph_reset_o,
    output logic                 target_reset_o,
    output logic                 escalated_o,
    output logic [1:0]           armed_action_o
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_AWAIT_SR = 2'd1;
    localparam logic [1:0] c_ST_AWAIT_P  = 2'd2;
    localparam logic [1:0] c_ST_FIRE     = 2'd3;

    localparam logic [1:0] c_ACT_NONE    = 2'd0;
    localparam logic [1:0] c_ACT_PERIPH  = 2'd1;
    localparam logic [1:0] c_ACT_TARGET  = 2'd2;
    localparam logic [1:0] c_ACT_DEFAULT = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(PATTERN_TRANSITIONS);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_edge_cnt;
    logic             r_pattern_detect;
    logic             r_periph_reset;
    logic             r_target_reset;
    logic             r_escalated;
    logic [1:0]       r_armed;

    logic w_sda_edge;
    logic w_fire_entry;
    logic w_rstact_legal;
    logic w_periph_act;
    logic w_target_act;
    logic w_timer_expire;

    assign w_sda_edge     = sda_posedge_i | sda_negedge_i;
    assign w_rstact_legal = (rstact_i[7:2] == 6'd0) && (rstact_i[1:0] != 2'd3);
    assign w_periph_act   = (r_armed == c_ACT_PERIPH) ||
                            ((r_armed == c_ACT_DEFAULT) && !r_escalated);
    assign w_target_act   = (r_armed == c_ACT_TARGET) ||
                            ((r_armed == c_ACT_DEFAULT) && r_escalated);

    always_comb begin
        w_state_next = r_state;
        w_fire_entry = 1'b0;
        if (!enable_i) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_cnt == c_CNT_MAX) w_state_next = c_ST_AWAIT_SR;
                end
                c_ST_AWAIT_SR: begin
                    if (scl_low_i || (r_edge_cnt >= 2'd2)) begin
                        w_state_next = c_ST_IDLE;
                    end else if (start_detected_i && scl_high_i) begin
                        w_state_next = c_ST_AWAIT_P;
                    end
                end
                c_ST_AWAIT_P: begin
                    if (r_edge_cnt >= 2'd2) begin
                        w_state_next = c_ST_IDLE;
                    end else if (stop_detected_i && scl_high_i) begin
                        w_state_next = c_ST_FIRE;
                        w_fire_entry = 1'b1;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first rising edge after SCL falls is the tail of the previous bit, not a pattern transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (!enable_i || (r_state != c_ST_IDLE) || scl_high_i) begin
            r_cnt <= '0;
        end else if ((r_cnt != c_CNT_MAX) &&
                     (sda_negedge_i || (sda_posedge_i && (r_cnt != '0)))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_edge_cnt <= 2'd0;
        end else if (!enable_i || (w_state_next != r_state)) begin
            r_edge_cnt <= 2'd0;
        end else if (w_sda_edge && (r_edge_cnt != 2'd3)) begin
            r_edge_cnt <= r_edge_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pattern_detect <= 1'b0;
            r_periph_reset   <= 1'b0;
            r_target_reset   <= 1'b0;
        end else begin
            r_pattern_detect <= w_fire_entry;
            r_periph_reset   <= w_fire_entry && w_periph_act;
            r_target_reset   <= w_fire_entry && w_target_act;
        end
    end

    // A write landing with the firing pattern supersedes the single-use return to default.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_armed <= c_ACT_DEFAULT;
        end else if (rstact_valid_i && w_rstact_legal) begin
            r_armed <= rstact_i[1:0];
        end else if (w_fire_entry) begin
            r_armed <= c_ACT_DEFAULT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_escalated <= 1'b0;
        end else if (w_fire_entry && (r_armed == c_ACT_DEFAULT)) begin
            r_escalated <= !r_escalated;
        end else if (escalation_clear_i || w_timer_expire) begin
            r_escalated <= 1'b0;
        end
    end

`ifdef TARGET_RESET_ESCALATION_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_timer_run;

    assign w_timer_expire = r_timer_run && r_escalated && (r_timer == TIMEOUT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer     <= '0;
            r_timer_run <= 1'b0;
        end else if (w_fire_entry && (r_armed == c_ACT_DEFAULT) && !r_escalated) begin
            r_timer     <= timeout_cycles_i;
            r_timer_run <= (timeout_cycles_i != '0);
        end else if (!r_escalated || w_timer_expire) begin
            r_timer_run <= 1'b0;
            if (w_timer_expire) r_timer <= '0;
        end else if (r_timer_run) begin
            r_timer <= r_timer - 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timer_expire   = 1'b0;
    assign w_unused_timeout = ^timeout_cycles_i;
`endif

    assign pattern_detect_o = r_pattern_detect;
    assign periph_reset_o   = r_periph_reset;
    assign target_reset_o   = r_target_reset;
    assign escalated_o      = r_escalated;
    assign armed_action_o   = r_armed;

endmodule
`default_nettype wire
